// File: rtl/d_input_debouncer.sv
// Input conditioner for the d_flipflop D pin: 2-flop synchroniser plus counter-qualified stability FSM.
// Optional registered edge pulses on rise/fall are enabled by defining DEBOUNCE_EDGE_PULSE_EN.
module d_input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic busy,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             dout_next;
    logic             busy_next;

    // din is only ever seen through sync2 so metastability never reaches the FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dout  <= dout_next;
            busy  <= busy_next;
        end
    end

    // Entering a CHECK state counts as the first stable sample, so cnt starts at 1
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dout_next  = dout;
        case (state)
            IDLE_LOW: begin
                if (sync2) begin
                    state_next = CHECK_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            CHECK_HIGH: begin
                if (!sync2) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    dout_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync2) begin
                    state_next = CHECK_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            CHECK_LOW: begin
                if (sync2) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    dout_next  = 1'b0;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
                dout_next  = 1'b0;
            end
        endcase
        busy_next = (state_next == CHECK_HIGH) || (state_next == CHECK_LOW);
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    // Pulses are registered alongside dout so they line up with its transition edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= dout_next & ~dout;
            fall <= ~dout_next & dout;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_d_input_debouncer.sv
// Self-checking bench for d_input_debouncer: directed boundary cases plus random din,
// compared against a run-length model; a second instance covers STABLE_CYCLES=2.
module tb_d_input_debouncer;

    localparam int S_A = 4;
    localparam int S_B = 2;

    logic clk;
    logic reset;
    logic din;
    logic din2;
    logic dout, busy, rise, fall;
    logic dout2, busy2, rise2, fall2;

    int checks = 0;
    int errors = 0;

    // Model state per instance: index 0 is the default build, index 1 the sweep build
    logic ms1 [2];
    logic ms2 [2];
    logic md  [2];
    logic mb  [2];
    logic mr  [2];
    logic mf  [2];
    int   run [2];
    int   stab [2];

    d_input_debouncer #(.STABLE_CYCLES(S_A), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .din(din),
        .dout(dout), .busy(busy), .rise(rise), .fall(fall)
    );

    d_input_debouncer #(.STABLE_CYCLES(S_B), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din2),
        .dout(dout2), .busy(busy2), .rise(rise2), .fall(fall2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            ms1[i] = 1'b0; ms2[i] = 1'b0; md[i] = 1'b0;
            mb[i] = 1'b0; mr[i] = 1'b0; mf[i] = 1'b0; run[i] = 0;
        end
    endtask

    // run counts consecutive FSM-visible samples that disagree with the current output level
    task automatic modelStep(input int i, input logic d);
        logic seen;
        seen   = ms2[i];
        ms2[i] = ms1[i];
        ms1[i] = d;
        mr[i]  = 1'b0;
        mf[i]  = 1'b0;
        if (seen != md[i]) begin
            run[i]++;
            if (run[i] == stab[i]) begin
                md[i]  = seen;
                run[i] = 0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                mr[i] = seen;
                mf[i] = ~seen;
`endif
            end
        end else begin
            run[i] = 0;
        end
        mb[i] = (run[i] > 0);
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("dout_s4", dout,  md[0]);
        checkOutput("busy_s4", busy,  mb[0]);
        checkOutput("rise_s4", rise,  mr[0]);
        checkOutput("fall_s4", fall,  mf[0]);
        checkOutput("dout_s2", dout2, md[1]);
        checkOutput("busy_s2", busy2, mb[1]);
        checkOutput("rise_s2", rise2, mr[1]);
        checkOutput("fall_s2", fall2, mf[1]);
        checkOutput("pulse_excl_s4", rise & fall, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            modelReset();
        end else begin
            modelStep(0, din);
            modelStep(1, din2);
        end
        #1;
        checkAll();
    endtask

    task automatic applyStimulus(input logic d, input logic d2, input int n);
        din  = d;
        din2 = d2;
        repeat (n) tick();
    endtask

    initial begin
        int lat;
        stab[0] = S_A;
        stab[1] = S_B;

        // Reset held with din high: outputs must stay low across edges
        reset = 1'b0;
        din   = 1'b1;
        din2  = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_dout", dout, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rise", rise, 1'b0);
        checkOutput("rst_fall", fall, 1'b0);
        tick();
        tick();
        #4;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4);

        // Short glitches, including the one that reverts on the qualifying edge
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 6);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("glitch_dout", dout, 1'b0);

        // Clean rise: dout follows the capture edge by five edges
        din = 1'b1;
        lat = -1;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (dout === 1'b1 && lat < 0) lat = n;
        end
        checkInt("rise_latency", lat, 5);

        // Clean fall
        din = 1'b0;
        lat = -1;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (dout === 1'b0 && lat < 0) lat = n;
        end
        checkInt("fall_latency", lat, 5);

        // Sweep instance: one-sample glitch rejected, two-sample pulse accepted at k+3
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 6);
        checkOutput("sweep_glitch_dout", dout2, 1'b0);
        din2 = 1'b1;
        lat = -1;
        for (int n = 0; n < 8; n++) begin
            if (n == 2) din2 = 1'b0;
            tick();
            if (dout2 === 1'b1 && lat < 0) lat = n;
        end
        checkInt("sweep_latency", lat, 3);
        applyStimulus(1'b0, 1'b0, 6);

        // Reset in the middle of a CHECK_LOW qualification
        applyStimulus(1'b1, 1'b1, 10);
        checkOutput("pre_rst_dout", dout, 1'b1);
        applyStimulus(1'b0, 1'b0, 4);
        checkOutput("pre_rst_busy", busy, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midrst_dout", dout, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        modelReset();
        tick();
        tick();
        #3;
        reset = 1'b1;

        // Random din with a bias towards holding the level long enough to qualify
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) din  = ~din;
            if ($urandom_range(0, 2) == 0) din2 = ~din2;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
